fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit.
//
// Walks IDLE -> FETCH -> VALID -> FETCH ... and holds one instruction word plus
// its PC for the core. A taken target with bit 1 set parks the unit in HALT
// with the sticky misaligned flag raised, until reset.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/imem_addr    fetch request and address (address always equals pc)
//   imem_rvalid/rdata     instruction memory response, only used in FETCH
//   pc, pc_plus4, instr   held instruction and its address
//   instr_valid           pc/instr valid for the core (state VALID)
//   instr_ack             core consumed instr; next-PC inputs valid this cycle
//   pc_src, imm_ext,      next-PC select and operands
//   alu_result
//   misaligned            sticky misaligned-target flag
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    output logic        misaligned
);

    typedef enum logic [1:0] {StIdle, StFetch, StValid, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        misaligned_q, misaligned_d;
    logic        imem_req_q;
    logic        instr_valid_q;
    logic [31:0] next_pc;

    // Next-PC select; adds wrap at 32 bits.
    always_comb begin
        case (pc_src)
            2'b01:   next_pc = pc_q + imm_ext;
            2'b10:   next_pc = {alu_result[31:1], 1'b0};
            default: next_pc = pc_q + 32'd4;
        endcase
        // Targets are always halfword aligned; bit 1 is what gets trapped.
        next_pc[0] = 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        misaligned_d = misaligned_q;
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (instr_ack) begin
                    if (next_pc[1]) begin
                        // Leave pc on the offending instruction for debug.
                        misaligned_d = 1'b1;
                        state_d      = StHalt;
                    end else begin
                        pc_d    = next_pc;
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StHalt;
        endcase
    end

    // Handshake outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            misaligned_q  <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            misaligned_q  <= misaligned_d;
            imem_req_q    <= (state_d == StFetch);
            instr_valid_q <= (state_d == StValid);
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver pushes {pc, instr} expected for
// each fetched instruction, a negedge monitor pops and compares whenever
// instr_valid rises, and checks pc/instr stay stable while held.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic [1:0]  pc_src;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        misaligned;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] exp_q[$];
    bit          seen = 1'b0;
    logic [31:0] held_pc;
    logic [31:0] held_instr;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ack  (instr_ack),
        .pc_src     (pc_src),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .misaligned (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop on the first VALID cycle of each instruction, then check hold.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got pc %h instr %h expected none", pc, instr);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("sb_pc", pc, e[63:32]);
                    check("sb_instr", instr, e[31:0]);
                end
                held_pc    = pc;
                held_instr = instr;
                seen       = 1'b1;
            end else begin
                check("hold_pc", pc, held_pc);
                check("hold_instr", instr, held_instr);
            end
            if (instr_ack) seen = 1'b0;
        end else begin
            seen = 1'b0;
        end
    end

    // One instruction: wait for FETCH, respond after rv_dly cycles, ack after
    // ack_dly cycles. With stray set, inject ack during FETCH and rvalid in VALID.
    task automatic do_instr(input logic [31:0] exp_pc, input logic [31:0] word,
                            input int rv_dly, input int ack_dly, input logic [1:0] src,
                            input logic [31:0] imm, input logic [31:0] alu, input bit stray);
        int n;
        int req_cycles;
        exp_q.push_back({exp_pc, word});
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (imem_req !== 1'b1) begin
            check("req_timeout", {31'b0, imem_req}, 32'd1);
            return;
        end
        check("imem_addr", imem_addr, exp_pc);
        check("pc_plus4", pc_plus4, exp_pc + 32'd4);
        req_cycles = 0;
        for (int i = 0; i < rv_dly; i++) begin
            if (stray) begin
                instr_ack = 1'b1;
                pc_src    = 2'b01;
                imm_ext   = 32'h0000_0100;
            end
            req_cycles += int'(imem_req);
            @(posedge clk);
            #1;
        end
        instr_ack   = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        req_cycles += int'(imem_req);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        check("req_cycles", req_cycles, rv_dly + 1);
        check("valid_after_rvalid", {31'b0, instr_valid}, 32'd1);
        for (int i = 0; i < ack_dly; i++) begin
            if (stray) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end
            @(posedge clk);
            #1;
        end
        imem_rvalid = 1'b0;
        pc_src      = src;
        imm_ext     = imm;
        alu_result  = alu;
        instr_ack   = 1'b1;
        @(posedge clk);
        #1;
        instr_ack = 1'b0;
        pc_src    = 2'b00;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_misaligned", {31'b0, misaligned}, 32'd0);
        rst_n = 1'b1;
        check("idle_req", {31'b0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("idle_one_cycle", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        int prev;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ack   = 1'b0;
        pc_src      = 2'b00;
        imm_ext     = 32'h0;
        alu_result  = 32'h0;
        #1;
        apply_reset();

        // Sequential stream at one instruction per two cycles.
        prev = cyc;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) check("throughput", cyc - prev, 32'd2);
            prev = cyc;
            do_instr(32'(k * 4), 32'h0010_0093 + 32'(k), 0, 0, 2'b00, 32'h0, 32'h0, 1'b0);
        end

        // Branch backwards, branch forwards, then JALR with bit 0 cleared.
        do_instr(32'h10, 32'hFE00_0CE3, 0, 0, 2'b01, 32'hFFFF_FFF8, 32'h0, 1'b0);
        do_instr(32'h08, 32'h0000_0C63, 0, 0, 2'b01, 32'h0000_0018, 32'h0, 1'b0);
        do_instr(32'h20, 32'h1050_00E7, 0, 0, 2'b10, 32'h0, 32'h0000_0105, 1'b0);

        // Stalls with stray ack in FETCH and stray rvalid in VALID.
        do_instr(32'h104, 32'h0041_0113, 3, 4, 2'b00, 32'h0, 32'h0, 1'b1);
        do_instr(32'h108, 32'h0000_8067, 0, 0, 2'b10, 32'h0, 32'hFFFF_FFFD, 1'b0);

        // Wrap-around from the top of the address space.
        do_instr(32'hFFFF_FFFC, 32'h0000_0013, 0, 0, 2'b00, 32'h0, 32'h0, 1'b0);
        do_instr(32'h0, 32'h0020_0113, 0, 0, 2'b00, 32'h0, 32'h0, 1'b0);

        // Reset mid-FETCH with a pending response that must be dropped.
        check("fetch_at_4_req", {31'b0, imem_req}, 32'd1);
        check("fetch_at_4_addr", imem_addr, 32'h4);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        rst_n       = 1'b0;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        check("midfetch_pc", pc, 32'h0);
        check("midfetch_instr", instr, 32'h0000_0013);
        check("midfetch_valid", {31'b0, instr_valid}, 32'd0);
        check("midfetch_req", {31'b0, imem_req}, 32'd0);
        apply_reset();

        // Misaligned target: pc 0 + 6 has bit 1 set.
        do_instr(32'h0, 32'h0060_006F, 0, 0, 2'b01, 32'h0000_0006, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("halt_misaligned", {31'b0, misaligned}, 32'd1);
            check("halt_pc", pc, 32'h0);
            check("halt_req", {31'b0, imem_req}, 32'd0);
            check("halt_valid", {31'b0, instr_valid}, 32'd0);
            imem_rvalid = 1'b1;
            instr_ack   = 1'b1;
            @(posedge clk);
            #1;
        end
        imem_rvalid = 1'b0;
        instr_ack   = 1'b0;

        // Reset out of HALT clears the sticky flag.
        apply_reset();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
